// File: rtl/trdb_emit_arbiter.sv
// Arbitrates software words and timer timestamps onto the emitter's sw/tu request ports.
// Software words queue in a small FIFO; the timer keeps only its newest value.
module trdb_emit_arbiter #(
  parameter int unsigned SW_FIFO_DEPTH = 4,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned TIMER_WIDTH   = 40,
  parameter int unsigned DROP_CNT_W    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   trace_valid_i,
  input  logic                   flush_i,
  input  logic                   cnt_clr_i,
  input  logic                   sw_valid_i,
  input  logic [XLEN-1:0]        sw_word_i,
  input  logic                   tu_valid_i,
  input  logic [TIMER_WIDTH-1:0] tu_time_i,
  input  logic                   tu_fulltime_i,
  output logic                   emit_sw_valid_o,
  output logic [XLEN-1:0]        emit_sw_word_o,
  input  logic                   emit_sw_grant_i,
  output logic                   emit_tu_valid_o,
  output logic [TIMER_WIDTH-1:0] emit_tu_time_o,
  output logic                   emit_tu_fulltime_o,
  input  logic                   emit_tu_grant_i,
  output logic [DROP_CNT_W-1:0]  sw_drop_cnt_o,
  output logic [DROP_CNT_W-1:0]  tu_drop_cnt_o,
  output logic                   busy_o
);

  localparam int unsigned AW = $clog2(SW_FIFO_DEPTH);

  typedef enum logic {PREF_SW, PREF_TU} prefState_e;

  prefState_e             state_q, state_d;
  logic [XLEN-1:0]        fifoMem_q [SW_FIFO_DEPTH];
  logic [AW-1:0]          rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [AW:0]            count_q, count_d;
  logic                   slotValid_q, slotValid_d;
  logic [TIMER_WIDTH-1:0] slotTime_q, slotTime_d;
  logic                   slotFull_q, slotFull_d;
  logic                   swReq_q, swReq_d, tuReq_q, tuReq_d;
  logic [DROP_CNT_W-1:0]  swDrop_q, swDrop_d, tuDrop_q, tuDrop_d;
  logic                   swPop, tuPop, swPush, tuLoad, fifoFull;
  logic                   swDropInc, tuDropInc, swPend, tuPend, holdReq;

  always_comb begin
    swPop     = emit_sw_grant_i & swReq_q;
    tuPop     = emit_tu_grant_i & tuReq_q;
    fifoFull  = (count_q == (AW+1)'(SW_FIFO_DEPTH));
    swPush    = sw_valid_i & ~flush_i & (~fifoFull | swPop);
    tuLoad    = tu_valid_i & ~flush_i;
    swDropInc = sw_valid_i & ~flush_i & fifoFull & ~swPop;
    tuDropInc = tuLoad & slotValid_q & ~tuPop;

    state_d     = state_q;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    count_d     = count_q + (AW+1)'(swPush) - (AW+1)'(swPop);
    slotValid_d = slotValid_q;
    slotTime_d  = slotTime_q;
    slotFull_d  = slotFull_q;
    swDrop_d    = swDrop_q;
    tuDrop_d    = tuDrop_q;
    swReq_d     = 1'b0;
    tuReq_d     = 1'b0;

    if (swPop)  rdPtr_d = rdPtr_q + AW'(1);
    if (swPush) wrPtr_d = wrPtr_q + AW'(1);

    // An overwritten slot keeps any full-time marker so the emitter never loses a resync point.
    if (tuLoad) begin
      slotValid_d = 1'b1;
      slotTime_d  = tu_time_i;
      slotFull_d  = tuDropInc ? (slotFull_q | tu_fulltime_i) : tu_fulltime_i;
    end else if (tuPop) begin
      slotValid_d = 1'b0;
    end

    if (cnt_clr_i) swDrop_d = '0;
    else if (swDropInc && (swDrop_q != '1)) swDrop_d = swDrop_q + DROP_CNT_W'(1);
    if (cnt_clr_i) tuDrop_d = '0;
    else if (tuDropInc && (tuDrop_q != '1)) tuDrop_d = tuDrop_q + DROP_CNT_W'(1);

    if (flush_i) begin
      count_d     = '0;
      rdPtr_d     = '0;
      wrPtr_d     = '0;
      slotValid_d = 1'b0;
    end else if (swPop) begin
      state_d = PREF_TU;
    end else if (tuPop) begin
      state_d = PREF_SW;
    end

    // A presented request stays put until granted; a fresh choice is made only after a grant or from idle.
    swPend  = (count_d != '0);
    tuPend  = slotValid_d;
    holdReq = trace_valid_i | ~(swPop | tuPop);
    if (holdReq && (swReq_q || tuReq_q)) begin
      swReq_d = swReq_q & swPend;
      tuReq_d = tuReq_q & tuPend;
    end else if (swPend && tuPend) begin
      swReq_d = (state_d == PREF_SW);
      tuReq_d = (state_d == PREF_TU);
    end else begin
      swReq_d = swPend;
      tuReq_d = tuPend;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= PREF_TU;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      slotValid_q <= 1'b0;
      slotTime_q  <= '0;
      slotFull_q  <= 1'b0;
      swReq_q     <= 1'b0;
      tuReq_q     <= 1'b0;
      swDrop_q    <= '0;
      tuDrop_q    <= '0;
    end else begin
      state_q     <= state_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      slotValid_q <= slotValid_d;
      slotTime_q  <= slotTime_d;
      slotFull_q  <= slotFull_d;
      swReq_q     <= swReq_d;
      tuReq_q     <= tuReq_d;
      swDrop_q    <= swDrop_d;
      tuDrop_q    <= tuDrop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (swPush) fifoMem_q[wrPtr_q] <= sw_word_i;
  end

  assign emit_sw_valid_o    = swReq_q;
  assign emit_sw_word_o     = swReq_q ? fifoMem_q[rdPtr_q] : '0;
  assign emit_tu_valid_o    = tuReq_q;
  assign emit_tu_time_o     = tuReq_q ? slotTime_q : '0;
  assign emit_tu_fulltime_o = tuReq_q & slotFull_q;
  assign sw_drop_cnt_o      = swDrop_q;
  assign tu_drop_cnt_o      = tuDrop_q;
  assign busy_o             = (count_q != '0) | slotValid_q;

`ifndef SYNTHESIS
  // A grant for a source that is not requesting indicates a broken emitter.
  swGrantNoReq: assert property (@(posedge clk_i) disable iff (rst_i) emit_sw_grant_i |-> swReq_q);
  tuGrantNoReq: assert property (@(posedge clk_i) disable iff (rst_i) emit_tu_grant_i |-> tuReq_q);
`endif

endmodule

// File: tb/tb_trdb_emit_arbiter.sv
// Directed vector bench for trdb_emit_arbiter: a table of single-cycle vectors
// followed by hand-built sequences for FIFO overflow, saturation, flush and reset.
module tb_trdb_emit_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trace_valid_i, flush_i, cnt_clr_i;
  logic        sw_valid_i;
  logic [31:0] sw_word_i;
  logic        tu_valid_i;
  logic [39:0] tu_time_i;
  logic        tu_fulltime_i;
  logic        emit_sw_valid_o;
  logic [31:0] emit_sw_word_o;
  logic        emit_sw_grant_i;
  logic        emit_tu_valid_o;
  logic [39:0] emit_tu_time_o;
  logic        emit_tu_fulltime_o;
  logic        emit_tu_grant_i;
  logic [7:0]  sw_drop_cnt_o, tu_drop_cnt_o;
  logic        busy_o;

  trdb_emit_arbiter #(
    .SW_FIFO_DEPTH(4), .XLEN(32), .TIMER_WIDTH(40), .DROP_CNT_W(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trace_valid_i(trace_valid_i), .flush_i(flush_i),
    .cnt_clr_i(cnt_clr_i), .sw_valid_i(sw_valid_i), .sw_word_i(sw_word_i),
    .tu_valid_i(tu_valid_i), .tu_time_i(tu_time_i), .tu_fulltime_i(tu_fulltime_i),
    .emit_sw_valid_o(emit_sw_valid_o), .emit_sw_word_o(emit_sw_word_o),
    .emit_sw_grant_i(emit_sw_grant_i), .emit_tu_valid_o(emit_tu_valid_o),
    .emit_tu_time_o(emit_tu_time_o), .emit_tu_fulltime_o(emit_tu_fulltime_o),
    .emit_tu_grant_i(emit_tu_grant_i), .sw_drop_cnt_o(sw_drop_cnt_o),
    .tu_drop_cnt_o(tu_drop_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        trace, flush, clr, swV;
    logic [31:0] swWord;
    logic        tuV;
    logic [39:0] tuTime;
    logic        tuFull, swGnt, tuGnt;
  } stim_t;

  typedef struct packed {
    logic        swV;
    logic [31:0] swWord;
    logic        tuV;
    logic [39:0] tuTime;
    logic        tuFull, busy;
    logic [7:0]  swDrop, tuDrop;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vecs[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic stim_t st(input logic trace, input logic flush, input logic clr,
                               input logic swV, input logic [31:0] swWord,
                               input logic tuV, input logic [39:0] tuTime, input logic tuFull,
                               input logic swGnt, input logic tuGnt);
    stim_t s;
    s.trace = trace;  s.flush = flush;   s.clr = clr;       s.swV = swV;
    s.swWord = swWord; s.tuV = tuV;      s.tuTime = tuTime; s.tuFull = tuFull;
    s.swGnt = swGnt;  s.tuGnt = tuGnt;
    return s;
  endfunction

  function automatic exp_t ex(input logic swV, input logic [31:0] swWord,
                              input logic tuV, input logic [39:0] tuTime, input logic tuFull,
                              input logic busy, input logic [7:0] swDrop, input logic [7:0] tuDrop);
    exp_t e;
    e.swV = swV;       e.swWord = swWord; e.tuV = tuV;       e.tuTime = tuTime;
    e.tuFull = tuFull; e.busy = busy;     e.swDrop = swDrop; e.tuDrop = tuDrop;
    return e;
  endfunction

  task automatic addVec(input string name, input stim_t s, input exp_t e);
    vec_t v;
    v.name = name; v.s = s; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic driveInputs(input stim_t s);
    trace_valid_i   = s.trace;
    flush_i         = s.flush;
    cnt_clr_i       = s.clr;
    sw_valid_i      = s.swV;
    sw_word_i       = s.swWord;
    tu_valid_i      = s.tuV;
    tu_time_i       = s.tuTime;
    tu_fulltime_i   = s.tuFull;
    emit_sw_grant_i = s.swGnt;
    emit_tu_grant_i = s.tuGnt;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk_i);
    driveInputs(s);
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t got;
    got = ex(emit_sw_valid_o, emit_sw_word_o, emit_tu_valid_o, emit_tu_time_o,
             emit_tu_fulltime_o, busy_o, sw_drop_cnt_o, tu_drop_cnt_o);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL %s: got swV=%0b word=%h tuV=%0b time=%h full=%0b busy=%0b swDrop=%0d tuDrop=%0d, expected swV=%0b word=%h tuV=%0b time=%h full=%0b busy=%0b swDrop=%0d tuDrop=%0d",
               name, got.swV, got.swWord, got.tuV, got.tuTime, got.tuFull, got.busy, got.swDrop, got.tuDrop,
               e.swV, e.swWord, e.tuV, e.tuTime, e.tuFull, e.busy, e.swDrop, e.tuDrop);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t idle;
    exp_t  zero;
    logic [31:0] bWords [5];
    logic [31:0] cWords [6];

    idle = st(0, 0, 0, 0, 32'h0, 0, 40'h0, 0, 0, 0);
    zero = ex(0, 32'h0, 0, 40'h0, 0, 0, 8'd0, 8'd0);
    bWords = '{32'hB0B0_0000, 32'hB1B1_1111, 32'hB2B2_2222, 32'hB3B3_3333, 32'hB4B4_4444};
    cWords = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hC000_0004, 32'hC000_0005};

    rst_i = 1'b1;
    driveInputs(idle);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_state", zero);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single sw word round trip, then timer overwrite under trace, then sw/tu alternation.
    addVec("t1_idle",      idle, zero);
    addVec("t1_push",      st(0,0,0,1,32'hDEADBEEF,0,40'h0,0,0,0), ex(1,32'hDEADBEEF,0,40'h0,0,1,8'd0,8'd0));
    addVec("t1_grant",     st(0,0,0,0,32'h0,0,40'h0,0,1,0),        zero);
    addVec("t4_tu100",     st(1,0,0,0,32'h0,1,40'd100,1,0,0),      ex(0,32'h0,1,40'd100,1,1,8'd0,8'd0));
    addVec("t4_tu200",     st(1,0,0,0,32'h0,1,40'd200,0,0,0),      ex(0,32'h0,1,40'd200,1,1,8'd0,8'd1));
    addVec("t4_grant",     st(0,0,0,0,32'h0,0,40'h0,0,0,1),        ex(0,32'h0,0,40'h0,0,0,8'd0,8'd1));
    addVec("t4_clr",       st(0,0,1,0,32'h0,0,40'h0,0,0,0),        zero);
    addVec("t3_tu_setup",  st(1,0,0,0,32'h0,1,40'h11,0,0,0),       ex(0,32'h0,1,40'h11,0,1,8'd0,8'd0));
    addVec("t3_sw_a1",     st(1,0,0,1,32'hA000_0001,0,40'h0,0,0,0), ex(0,32'h0,1,40'h11,0,1,8'd0,8'd0));
    addVec("t3_sw_a2",     st(1,0,0,1,32'hA000_0002,0,40'h0,0,0,0), ex(0,32'h0,1,40'h11,0,1,8'd0,8'd0));
    addVec("t3_sw_a3",     st(1,0,0,1,32'hA000_0003,0,40'h0,0,0,0), ex(0,32'h0,1,40'h11,0,1,8'd0,8'd0));
    addVec("t3_g1_tu",     st(0,0,0,0,32'h0,1,40'h12,0,0,1),       ex(1,32'hA000_0001,0,40'h0,0,1,8'd0,8'd0));
    addVec("t3_g2_sw",     st(0,0,0,0,32'h0,1,40'h13,0,1,0),       ex(0,32'h0,1,40'h13,0,1,8'd0,8'd1));
    addVec("t3_g3_tu",     st(0,0,0,0,32'h0,1,40'h14,0,0,1),       ex(1,32'hA000_0002,0,40'h0,0,1,8'd0,8'd1));
    addVec("t3_g4_sw",     st(0,0,0,0,32'h0,1,40'h15,0,1,0),       ex(0,32'h0,1,40'h15,0,1,8'd0,8'd2));
    addVec("t3_g5_tu",     st(0,0,0,0,32'h0,1,40'h16,0,0,1),       ex(1,32'hA000_0003,0,40'h0,0,1,8'd0,8'd2));
    addVec("t3_g6_sw",     st(0,0,0,0,32'h0,1,40'h17,0,1,0),       ex(0,32'h0,1,40'h17,0,1,8'd0,8'd3));
    addVec("t3_g7_tu",     st(0,0,0,0,32'h0,0,40'h0,0,0,1),        ex(0,32'h0,0,40'h0,0,0,8'd0,8'd3));
    addVec("t3_clr",       st(0,0,1,0,32'h0,0,40'h0,0,0,0),        zero);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      checkOutput(vecs[i].name, vecs[i].e);
    end

    // Five pushes into a four-entry FIFO during a ten-cycle trace burst.
    for (int i = 0; i < 5; i++) applyStimulus(st(1,0,0,1,bWords[i],0,40'h0,0,0,0));
    checkOutput("t2_overflow", ex(1,bWords[0],0,40'h0,0,1,8'd1,8'd0));
    for (int i = 0; i < 5; i++) applyStimulus(st(1,0,0,0,32'h0,0,40'h0,0,0,0));
    checkOutput("t2_trace_hold", ex(1,bWords[0],0,40'h0,0,1,8'd1,8'd0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(st(0,0,0,0,32'h0,0,40'h0,0,1,0));
      if (i < 3) checkOutput($sformatf("t2_drain%0d", i), ex(1,bWords[i+1],0,40'h0,0,1,8'd1,8'd0));
      else       checkOutput("t2_empty", ex(0,32'h0,0,40'h0,0,0,8'd1,8'd0));
    end

    // Full FIFO push/pop in one cycle, counter saturation and clear priority.
    applyStimulus(st(0,0,1,0,32'h0,0,40'h0,0,0,0));
    checkOutput("t5_clr", zero);
    for (int i = 0; i < 4; i++) applyStimulus(st(0,0,0,1,cWords[i],0,40'h0,0,0,0));
    checkOutput("t5_full", ex(1,cWords[0],0,40'h0,0,1,8'd0,8'd0));
    applyStimulus(st(0,0,0,1,cWords[4],0,40'h0,0,1,0));
    checkOutput("t5_push_pop_full", ex(1,cWords[1],0,40'h0,0,1,8'd0,8'd0));
    applyStimulus(st(0,0,0,1,cWords[5],0,40'h0,0,0,0));
    checkOutput("t5_drop1", ex(1,cWords[1],0,40'h0,0,1,8'd1,8'd0));
    for (int i = 0; i < 254; i++) applyStimulus(st(0,0,0,1,32'hEEEE_0000 + 32'(i),0,40'h0,0,0,0));
    checkOutput("t5_cnt255", ex(1,cWords[1],0,40'h0,0,1,8'd255,8'd0));
    applyStimulus(st(0,0,0,1,32'hEEEE_FFFF,0,40'h0,0,0,0));
    checkOutput("t5_saturate", ex(1,cWords[1],0,40'h0,0,1,8'd255,8'd0));
    applyStimulus(st(0,0,1,1,32'hEEEE_EEEE,0,40'h0,0,0,0));
    checkOutput("t5_clr_beats_inc", ex(1,cWords[1],0,40'h0,0,1,8'd0,8'd0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(st(0,0,0,0,32'h0,0,40'h0,0,1,0));
      if (i < 3) checkOutput($sformatf("t5_drain%0d", i), ex(1,cWords[i+2],0,40'h0,0,1,8'd0,8'd0));
      else       checkOutput("t5_empty", zero);
    end

    // Flush discards queued and same-cycle pushes but leaves counters alone.
    applyStimulus(st(0,0,0,1,32'hD000_0000,0,40'h0,0,0,0));
    checkOutput("t6_push_d0", ex(1,32'hD000_0000,0,40'h0,0,1,8'd0,8'd0));
    applyStimulus(st(0,0,0,1,32'hD000_0001,1,40'h55,1,0,0));
    checkOutput("t6_hold_sw", ex(1,32'hD000_0000,0,40'h0,0,1,8'd0,8'd0));
    applyStimulus(st(0,0,0,0,32'h0,1,40'h66,0,0,0));
    checkOutput("t6_tu_drop", ex(1,32'hD000_0000,0,40'h0,0,1,8'd0,8'd1));
    applyStimulus(st(0,1,0,1,32'hD000_0002,1,40'h77,1,0,0));
    checkOutput("t6_flush", ex(0,32'h0,0,40'h0,0,0,8'd0,8'd1));
    applyStimulus(st(0,0,0,1,32'hE000_0000,0,40'h0,0,0,0));
    applyStimulus(st(0,0,0,1,32'hE000_0001,0,40'h0,0,0,0));
    checkOutput("t6_burst", ex(1,32'hE000_0000,0,40'h0,0,1,8'd0,8'd1));
    driveInputs(idle);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("t6_async_reset", zero);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(st(0,0,0,1,32'hF000_0000,0,40'h0,0,0,0));
    checkOutput("t6_after_reset", ex(1,32'hF000_0000,0,40'h0,0,1,8'd0,8'd0));
    applyStimulus(idle);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
